// File: rtl/gas_pump_dispenser_meter.sv
// gas_pump_dispenser_meter: plant-side model of the fuel valve and flow meter.
// Ramps the valve after fuel_in, meters volume in pulses, and raises
// pressureSensor (STOP) on tank_full or, optionally, a reached preset.
// Optional feature macro: GAS_DISPENSER_PRESET_EN (preset register and
// preset-reached STOP condition). Without it preset_value is ignored and
// preset_load only clears volume in IDLE.
module gas_pump_dispenser_meter #(
  parameter int unsigned VOL_W     = 12,
  parameter int unsigned PULSE_DIV = 4,
  parameter int unsigned RAMP      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fuel_in,
  input  logic             tank_full,
  input  logic             preset_load,
  input  logic [VOL_W-1:0] preset_value,
  output logic             pressureSensor,
  output logic             vol_pulse,
  output logic [VOL_W-1:0] volume,
  output logic [1:0]       State_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_FLOW = 2'd2,
    S_STOP = 2'd3
  } state_t;

  localparam int unsigned RW = (RAMP > 1) ? $clog2(RAMP) : 1;
  localparam int unsigned DW = $clog2(PULSE_DIV);
  localparam logic [RW-1:0]    RAMP_LAST = RW'(RAMP - 1);
  localparam logic [DW-1:0]    DIV_LAST  = DW'(PULSE_DIV - 1);
  localparam logic [VOL_W-1:0] VOL_MAX   = '1;

  state_t           state, state_nxt;
  logic [RW-1:0]    ramp_cnt, ramp_nxt;
  logic [DW-1:0]    div_cnt, div_nxt;
  logic [VOL_W-1:0] volume_q, volume_nxt;
  logic             pulse_q, pulse_nxt;
  logic             preset_hit;

`ifdef GAS_DISPENSER_PRESET_EN
  logic [VOL_W-1:0] preset_q;

  // Preset register: loaded only while idle, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      preset_q <= '0;
    end else if (state == S_IDLE && preset_load) begin
      preset_q <= preset_value;
    end
  end

  assign preset_hit = (preset_q != '0) && (volume_q == preset_q);
`else
  logic preset_unused;
  assign preset_unused = ^preset_value;
  assign preset_hit    = 1'b0;
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ramp_cnt <= '0;
      div_cnt  <= '0;
      volume_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ramp_cnt <= ramp_nxt;
      div_cnt  <= div_nxt;
      volume_q <= volume_nxt;
      pulse_q  <= pulse_nxt;
    end
  end

  // Next-state and metering logic; fuel_in low always wins back to IDLE.
  always_comb begin
    state_nxt  = state;
    ramp_nxt   = ramp_cnt;
    div_nxt    = div_cnt;
    volume_nxt = volume_q;
    pulse_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (preset_load) begin
          volume_nxt = '0;
        end else if (fuel_in) begin
          state_nxt = S_RAMP;
          ramp_nxt  = '0;
        end
      end
      S_RAMP: begin
        if (!fuel_in) begin
          state_nxt = S_IDLE;
        end else if (ramp_cnt == RAMP_LAST) begin
          state_nxt = S_FLOW;
          div_nxt   = '0;
        end else begin
          ramp_nxt = ramp_cnt + 1'b1;
        end
      end
      S_FLOW: begin
        if (!fuel_in) begin
          state_nxt = S_IDLE;
        end else if (tank_full || preset_hit) begin
          state_nxt = S_STOP;
        end else if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (volume_q != VOL_MAX) begin
            volume_nxt = volume_q + 1'b1;
            pulse_nxt  = 1'b1;
          end
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (!fuel_in) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign pressureSensor = (state == S_STOP);
  assign vol_pulse      = pulse_q;
  assign volume         = volume_q;
  assign State_out      = state;

endmodule

// File: tb/tb_gas_pump_dispenser_meter.sv
// Directed bench for gas_pump_dispenser_meter (RAMP=2, PULSE_DIV=4).
// A second instance with VOL_W=3 exercises volume saturation.
module tb_gas_pump_dispenser_meter;

  logic        clk;
  logic        reset;
  logic        fuel_in, tank_full, preset_load;
  logic [11:0] preset_value;
  logic        pressureSensor, vol_pulse;
  logic [11:0] volume;
  logic [1:0]  State_out;

  logic        fuel3, tank3, load3;
  logic [2:0]  preset3;
  logic        press3, pulse3;
  logic [2:0]  volume3;
  logic [1:0]  state3;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  gas_pump_dispenser_meter #(.VOL_W(12), .PULSE_DIV(4), .RAMP(2)) dut (
    .clk(clk), .reset(reset), .fuel_in(fuel_in), .tank_full(tank_full),
    .preset_load(preset_load), .preset_value(preset_value),
    .pressureSensor(pressureSensor), .vol_pulse(vol_pulse),
    .volume(volume), .State_out(State_out)
  );

  gas_pump_dispenser_meter #(.VOL_W(3), .PULSE_DIV(4), .RAMP(2)) dut3 (
    .clk(clk), .reset(reset), .fuel_in(fuel3), .tank_full(tank3),
    .preset_load(load3), .preset_value(preset3),
    .pressureSensor(press3), .vol_pulse(pulse3),
    .volume(volume3), .State_out(state3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic pr,
                         input logic pu, input logic [11:0] vol);
    chk({tag, ".state"}, 32'(State_out), 32'(st));
    chk({tag, ".press"}, 32'(pressureSensor), 32'(pr));
    chk({tag, ".pulse"}, 32'(vol_pulse), 32'(pu));
    chk({tag, ".vol"}, 32'(volume), 32'(vol));
  endtask

  initial begin
    reset = 1'b1; fuel_in = 1'b0; tank_full = 1'b0; preset_load = 1'b0; preset_value = '0;
    fuel3 = 1'b0; tank3 = 1'b0; load3 = 1'b0; preset3 = '0;

    // Reset then idle for 5 cycles
    step(1);
    reset = 1'b0;
    chk_all("reset", 2'd0, 1'b0, 1'b0, 12'd0);
    step(5);
    chk_all("idle5", 2'd0, 1'b0, 1'b0, 12'd0);

    // Preset 3, fuel held high
    preset_load = 1'b1; preset_value = 12'd3;
    fuel_in = 1'b1;                       // preset_load wins over fuel_in
    step(1);
    preset_load = 1'b0;
    chk_all("load", 2'd0, 1'b0, 1'b0, 12'd0);
    step(1);                              // edge 1
    chk_all("p3.e1", 2'd1, 1'b0, 1'b0, 12'd0);
    step(1);                              // edge 2
    chk("p3.e2.state", 32'(State_out), 32'd1);
    step(1);                              // edge 3
    chk_all("p3.e3", 2'd2, 1'b0, 1'b0, 12'd0);
    step(3);                              // edge 6
    chk_all("p3.e6", 2'd2, 1'b0, 1'b0, 12'd0);
    step(1);                              // edge 7
    chk_all("p3.e7", 2'd2, 1'b0, 1'b1, 12'd1);
    step(1);                              // edge 8
    chk_all("p3.e8", 2'd2, 1'b0, 1'b0, 12'd1);
    step(3);                              // edge 11
    chk_all("p3.e11", 2'd2, 1'b0, 1'b1, 12'd2);
    step(4);                              // edge 15
    chk_all("p3.e15", 2'd2, 1'b0, 1'b1, 12'd3);
    step(1);                              // edge 16
`ifdef GAS_DISPENSER_PRESET_EN
    chk_all("p3.e16", 2'd3, 1'b1, 1'b0, 12'd3);
`else
    chk_all("p3.e16", 2'd2, 1'b0, 1'b0, 12'd3);
`endif
    tank_full = 1'b1;
    step(1);                              // edge 17
    tank_full = 1'b0;
    chk_all("p3.stop", 2'd3, 1'b1, 1'b0, 12'd3);
    fuel_in = 1'b0;
    step(1);
    chk_all("p3.release", 2'd0, 1'b0, 1'b0, 12'd3);

    // Preset 0, tank_full pulse after volume=2
    preset_load = 1'b1; preset_value = 12'd0;
    step(1);
    preset_load = 1'b0;
    chk("p0.clear", 32'(volume), 32'd0);
    fuel_in = 1'b1;
    step(11);                             // edge 11
    chk_all("p0.e11", 2'd2, 1'b0, 1'b1, 12'd2);
    tank_full = 1'b1;
    step(1);                              // edge 12
    tank_full = 1'b0;
    chk_all("tf.stop", 2'd3, 1'b1, 1'b0, 12'd2);
    step(3);
    chk_all("tf.hold", 2'd3, 1'b1, 1'b0, 12'd2);
    fuel_in = 1'b0;
    step(1);
    chk_all("tf.release", 2'd0, 1'b0, 1'b0, 12'd2);

    // fuel_in drops mid-RAMP
    fuel_in = 1'b1;
    step(1);
    chk("ramp.enter", 32'(State_out), 32'd1);
    fuel_in = 1'b0;
    step(1);
    chk_all("ramp.drop", 2'd0, 1'b0, 1'b0, 12'd2);

    // fuel_in drops mid-FLOW with divider at 2
    fuel_in = 1'b1;
    step(5);                              // edge 5: divider = 2
    chk_all("flow.div2", 2'd2, 1'b0, 1'b0, 12'd2);
    fuel_in = 1'b0;
    step(1);
    chk_all("flow.drop", 2'd0, 1'b0, 1'b0, 12'd2);
    step(3);
    chk_all("flow.after", 2'd0, 1'b0, 1'b0, 12'd2);

    // Residue discarded: restarted fill counts its first unit at edge 7
    fuel_in = 1'b1;
    step(6);
    chk_all("resid.e6", 2'd2, 1'b0, 1'b0, 12'd2);
    step(1);
    chk_all("resid.e7", 2'd2, 1'b0, 1'b1, 12'd3);
    fuel_in = 1'b0;
    step(1);

    // Saturation on the 3-bit instance
    fuel3 = 1'b1;
    step(31);                             // edge 31: seventh unit
    chk("sat.vol7", 32'(volume3), 32'd7);
    chk("sat.pulse7", 32'(pulse3), 32'd1);
    step(4);                              // edge 35: would-be eighth unit
    chk("sat.vol35", 32'(volume3), 32'd7);
    chk("sat.pulse35", 32'(pulse3), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("sat.nopulse", 32'(pulse3), 32'd0);
    end
    chk("sat.state", 32'(state3), 32'd2);
    chk("sat.vol", 32'(volume3), 32'd7);
    fuel3 = 1'b0;
    step(1);
    chk("sat.idle", 32'(state3), 32'd0);

    // Reset during STOP with fuel_in high
    fuel_in = 1'b1;
    step(3);
    chk("rst.flow", 32'(State_out), 32'd2);
    tank_full = 1'b1;
    step(1);
    tank_full = 1'b0;
    chk_all("rst.stop", 2'd3, 1'b1, 1'b0, 12'd3);
    reset = 1'b1;
    step(1);
    chk_all("rst.apply", 2'd0, 1'b0, 1'b0, 12'd0);
    reset = 1'b0;
    step(1);
    chk_all("rst.ramp", 2'd1, 1'b0, 1'b0, 12'd0);
    fuel_in = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
